alu_main_control: RTL and testbench

ALU_MAIN_CONTROL -- requirements
Module: alu_main_control

---
 rtl/alu_main_control.sv | 170 +++++++++++++++++
 tb/tb_alu_main_control.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_main_control.sv
// Multicycle main control FSM (Moore) for the ALU/memory datapath.
// Define ALU_MAIN_CONTROL_ORI_EN to add the ORIEX state for ori.
module alu_main_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   output logic [1:0] alu_op,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BEQ    = 4'd8,
      IMMEX  = 4'd9,
      IMMWB  = 4'd10,
      JUMP   = 4'd11
`ifdef ALU_MAIN_CONTROL_ORI_EN
      , ORIEX = 4'd12
`endif
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef ALU_MAIN_CONTROL_ORI_EN
   localparam logic [5:0] OP_ORI  = 6'b001101;
`endif

   state_t cur_state;
   state_t nxt_state;
   state_t dec_next;
   logic   dec_legal;
   logic   illegal_q;

   always_comb begin
      dec_next  = FETCH;
      dec_legal = 1'b1;
      unique case (1'b1)
         (opcode == OP_LW),
         (opcode == OP_SW):   dec_next = MEMADR;
         (opcode == OP_R):    dec_next = EXEC;
         (opcode == OP_BEQ):  dec_next = BEQ;
         (opcode == OP_ADDI): dec_next = IMMEX;
         (opcode == OP_J):    dec_next = JUMP;
`ifdef ALU_MAIN_CONTROL_ORI_EN
         (opcode == OP_ORI):  dec_next = ORIEX;
`endif
         default:             dec_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state <= FETCH;
         illegal_q <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         illegal_q <= (cur_state == DECODE) && !dec_legal;
      end
   end

   always_comb begin
      nxt_state     = FETCH;
      alu_op        = 2'b00;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      case (cur_state)
         FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            nxt_state = DECODE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            nxt_state = dec_next;
         end
         MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            i_or_d    = 1'b1;
            mem_read  = 1'b1;
            nxt_state = MEMWB;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            nxt_state = ALUWB;
         end
         ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         BEQ: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            pc_write_cond = 1'b1;
         end
         IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nxt_state = IMMWB;
         end
         IMMWB: reg_write = 1'b1;
         JUMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
         end
`ifdef ALU_MAIN_CONTROL_ORI_EN
         ORIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            nxt_state = IMMWB;
         end
`endif
         default: nxt_state = FETCH;
      endcase
   end

   assign illegal_op = illegal_q;
   assign state      = cur_state;

endmodule

// File: tb/tb_alu_main_control.sv
// Scoreboard bench for alu_main_control: per-cycle expected
// state/output vectors are queued, then popped at each negedge.
module tb_alu_main_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [1:0] alu_op;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
   logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_source;
   logic       illegal_op;
   logic [3:0] state;

   typedef struct packed {
      logic [3:0] st;
      logic       ill;
      logic [1:0] aop;
      logic [1:0] srcb;
      logic [1:0] pcs;
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
   } vec_t;

   vec_t       sb[$];
   int         n_tests = 0;
   int         n_fail = 0;
   logic [3:0] prev_s;

   alu_main_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode),
      .alu_op(alu_op), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg),
      .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .illegal_op(illegal_op),
      .state(state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference output table for each state.
   function automatic vec_t exp_vec(input logic [3:0] s, input logic ill);
      vec_t e;
      e = '0;
      e.st  = s;
      e.ill = ill;
      case (s)
         4'd0:  begin e.mrd = 1; e.irw = 1; e.pcw = 1; e.srcb = 2'b01; end
         4'd1:  e.srcb = 2'b11;
         4'd2:  begin e.srca = 1; e.srcb = 2'b10; end
         4'd3:  begin e.iord = 1; e.mrd = 1; end
         4'd4:  begin e.m2r = 1; e.rw = 1; end
         4'd5:  begin e.iord = 1; e.mwr = 1; end
         4'd6:  begin e.srca = 1; e.aop = 2'b10; end
         4'd7:  begin e.rdst = 1; e.rw = 1; end
         4'd8:  begin e.srca = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcwc = 1; end
         4'd9:  begin e.srca = 1; e.srcb = 2'b10; end
         4'd10: e.rw = 1;
         4'd11: begin e.pcs = 2'b10; e.pcw = 1; end
         4'd12: begin e.srca = 1; e.srcb = 2'b10; e.aop = 2'b11; end
         default: e.st = s;
      endcase
      return e;
   endfunction

   task automatic push(input logic [3:0] s);
      sb.push_back(exp_vec(s, (prev_s == 4'd1) && (s == 4'd0)));
      prev_s = s;
   endtask

   task automatic check(input string tag);
      vec_t obs, exp_v;
      @(negedge clk);
      obs = {state, illegal_op, alu_op, alu_src_b, pc_source,
             pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a};
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp_v = sb.pop_front();
         assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (state %0d vs %0d)",
                   tag, obs, exp_v, obs.st, exp_v.st);
         end
      end
   endtask

   // seq packs states low nibble first; starts in FETCH, ends where it ends.
   task automatic run(input logic [5:0] op, input logic [23:0] seq,
                      input int n, input string tag);
      opcode = op;
      for (int i = 0; i < n; i++) push(seq[4*i +: 4]);
      for (int i = 0; i < n; i++) check(tag);
   endtask

   initial begin
      rst_n  = 1'b0;
      opcode = 6'b111111;
      prev_s = 4'd0;
      repeat (2) @(posedge clk);
      push(4'd0);
      check("reset");
      rst_n = 1'b1;

      run(6'b100011, 24'h04321, 5, "lw");
      run(6'b000000, 24'h0761,  4, "rtype");
      run(6'b000100, 24'h081,   3, "beq");
      run(6'b000010, 24'h0b1,   3, "jump");
      run(6'b001000, 24'h0a91,  4, "addi");
      run(6'b101011, 24'h0521,  4, "sw");
`ifdef ALU_MAIN_CONTROL_ORI_EN
      run(6'b001101, 24'h0ac1,  4, "ori");
`else
      run(6'b001101, 24'h01,    2, "ori_illegal");
`endif
      run(6'b111111, 24'h01,    2, "illegal");
      run(6'b000100, 24'h081,   3, "beq_after_ill");
      run(6'b010101, 24'h01,    2, "illegal2");
      run(6'b111111, 24'h01,    2, "illegal_b2b");

      run(6'b100011, 24'h321,   3, "lw_part");
      rst_n = 1'b0;
      push(4'd0);
      check("reset_memrd");
      rst_n = 1'b1;
      run(6'b000000, 24'h0761,  4, "rtype_post_rst");

      // Reset while DECODE sees an illegal opcode: no pulse afterwards.
      run(6'b111111, 24'h1,     1, "ill_decode");
      rst_n = 1'b0;
      prev_s = 4'd0;
      push(4'd0);
      check("reset_decode");
      rst_n = 1'b1;
      run(6'b000010, 24'h0b1,   3, "jump_post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
